tpu_ctrl: RTL and testbench

Sequencer between the execute stage and the systolic matrix unit (TPU). It accepts matrix instructions from execute: lam, lbm, lacc, racc and matmul. It drives the array's write ports and shift enable, and generates the fixed-length compute sequence for matmul. It stalls the pipeline when a TPU command arrives while the array is busy, and reports completion through e_valid_o.

---
 rtl/tpu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_tpu_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_ctrl.sv
// tpu_ctrl: sequencer between the execute stage and the systolic matrix unit.
// Decodes lam/lbm/lacc/racc/matmul, drives the array write ports and shift
// enable, and times the fixed-length matmul compute sequence.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepting one command per cycle from execute
// COMPUTE | array shifts every cycle for 3*DIM-2 cycles; commands stall
// DONE    | one-cycle completion pulse on e_valid_o; commands stall
module tpu_ctrl #(
    parameter int unsigned DIM    = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              start_i,
    input  logic              write_enable_A_i,
    input  logic              write_enable_B_i,
    input  logic              write_enable_C_i,
    input  logic              read_acc_i,
    input  logic [4:0]        row_i,
    input  logic [4:0]        col_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] arr_rd_data_i,
    output logic              arr_we_a_o,
    output logic              arr_we_b_o,
    output logic              arr_we_c_o,
    output logic [4:0]        arr_row_o,
    output logic [4:0]        arr_col_o,
    output logic [DATA_W-1:0] arr_data_o,
    output logic              arr_shift_o,
    output logic              stall_o,
    output logic              e_valid_o,
    output logic [DATA_W-1:0] racc_data_o,
    output logic              racc_valid_o,
    output logic              err_o
);

    // Last counter value of the compute sequence; counting 0..CNT_LAST gives 3*DIM-2 shifts.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(3 * DIM - 3);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_a_q, we_a_d;
    logic                we_b_q, we_b_d;
    logic                we_c_q, we_c_d;
    logic [4:0]          row_q, row_d;
    logic [4:0]          col_q, col_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                shift_q, shift_d;
    logic                e_valid_q, e_valid_d;
    logic                err_q, err_d;
    logic                racc_pend_q, racc_pend_d;
    logic [DATA_W-1:0]   racc_data_q, racc_data_d;
    logic                racc_valid_q, racc_valid_d;

    logic [4:0]          cmd_vec;
    logic                cmd;
    logic                multi;
    logic                oob;
    logic                illegal;
    logic                accept;

    // Decode the presented command: presence, multiplicity, index range.
    always_comb begin
        cmd_vec = {start_i, write_enable_A_i, write_enable_B_i, write_enable_C_i, read_acc_i};
        cmd     = (cmd_vec != 5'd0) && !flush_i;
        multi   = $countones(cmd_vec) > 1;
        oob     = (32'(row_i) >= DIM) || (32'(col_i) >= DIM);
        // matmul carries no indices, so range only matters for the other commands
        illegal = multi || (!start_i && oob);
        accept  = cmd && (state_q == IDLE);
    end

    assign stall_o = cmd && (state_q != IDLE);

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_a_d       = 1'b0;
        we_b_d       = 1'b0;
        we_c_d       = 1'b0;
        row_d        = row_q;
        col_d        = col_q;
        data_d       = data_q;
        shift_d      = 1'b0;
        e_valid_d    = 1'b0;
        err_d        = 1'b0;
        racc_pend_d  = 1'b0;
        racc_data_d  = racc_data_q;
        racc_valid_d = 1'b0;

        // racc address was on the array for the whole last cycle; capture its data now
        if (racc_pend_q) begin
            racc_data_d  = arr_rd_data_i;
            racc_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else if (start_i) begin
                        state_d = COMPUTE;
                        cnt_d   = '0;
                        shift_d = 1'b1;
                    end else begin
                        row_d       = row_i;
                        col_d       = col_i;
                        we_a_d      = write_enable_A_i;
                        we_b_d      = write_enable_B_i;
                        we_c_d      = write_enable_C_i;
                        racc_pend_d = read_acc_i;
                        if (!read_acc_i) begin
                            data_d = data_i;
                        end
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    e_valid_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shift_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_a_q       <= 1'b0;
            we_b_q       <= 1'b0;
            we_c_q       <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            data_q       <= '0;
            shift_q      <= 1'b0;
            e_valid_q    <= 1'b0;
            err_q        <= 1'b0;
            racc_pend_q  <= 1'b0;
            racc_data_q  <= '0;
            racc_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_a_q       <= we_a_d;
            we_b_q       <= we_b_d;
            we_c_q       <= we_c_d;
            row_q        <= row_d;
            col_q        <= col_d;
            data_q       <= data_d;
            shift_q      <= shift_d;
            e_valid_q    <= e_valid_d;
            err_q        <= err_d;
            racc_pend_q  <= racc_pend_d;
            racc_data_q  <= racc_data_d;
            racc_valid_q <= racc_valid_d;
        end
    end

    assign arr_we_a_o   = we_a_q;
    assign arr_we_b_o   = we_b_q;
    assign arr_we_c_o   = we_c_q;
    assign arr_row_o    = row_q;
    assign arr_col_o    = col_q;
    assign arr_data_o   = data_q;
    assign arr_shift_o  = shift_q;
    assign e_valid_o    = e_valid_q;
    assign err_o        = err_q;
    assign racc_data_o  = racc_data_q;
    assign racc_valid_o = racc_valid_q;

endmodule

// File: tb/tb_tpu_ctrl.sv
// Bench for tpu_ctrl: directed scenarios followed by random command traffic,
// compared cycle by cycle against a timeline model of the sequencer.
module tb_tpu_ctrl;

    localparam int DIM  = 8;
    localparam int DW   = 32;
    localparam int SEQ  = 3 * DIM - 2;
    localparam int MAXC = 2400;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, start_i;
    logic          write_enable_A_i, write_enable_B_i, write_enable_C_i, read_acc_i;
    logic [4:0]    row_i, col_i;
    logic [DW-1:0] data_i;
    logic [DW-1:0] arr_rd_data_i;
    logic          arr_we_a_o, arr_we_b_o, arr_we_c_o;
    logic [4:0]    arr_row_o, arr_col_o;
    logic [DW-1:0] arr_data_o;
    logic          arr_shift_o, stall_o, e_valid_o, racc_valid_o, err_o;
    logic [DW-1:0] racc_data_o;

    always #5 clk = ~clk;

    tpu_ctrl #(.DIM(DIM), .DATA_W(DW), .CNT_W(5)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .start_i          (start_i),
        .write_enable_A_i (write_enable_A_i),
        .write_enable_B_i (write_enable_B_i),
        .write_enable_C_i (write_enable_C_i),
        .read_acc_i       (read_acc_i),
        .row_i            (row_i),
        .col_i            (col_i),
        .data_i           (data_i),
        .arr_rd_data_i    (arr_rd_data_i),
        .arr_we_a_o       (arr_we_a_o),
        .arr_we_b_o       (arr_we_b_o),
        .arr_we_c_o       (arr_we_c_o),
        .arr_row_o        (arr_row_o),
        .arr_col_o        (arr_col_o),
        .arr_data_o       (arr_data_o),
        .arr_shift_o      (arr_shift_o),
        .stall_o          (stall_o),
        .e_valid_o        (e_valid_o),
        .racc_data_o      (racc_data_o),
        .racc_valid_o     (racc_valid_o),
        .err_o            (err_o)
    );

    // Accumulator array seen by the DUT: written by its C strobe, read combinationally.
    logic [DW-1:0] cmem [DIM][DIM] = '{default: '0};
    always @(posedge clk) begin
        if (arr_we_c_o) cmem[arr_row_o[2:0]][arr_col_o[2:0]] <= arr_data_o;
    end
    assign arr_rd_data_i = cmem[arr_row_o[2:0]][arr_col_o[2:0]];

    // Reference model: expected events on an absolute cycle timeline.
    bit            ex_wa [MAXC], ex_wb [MAXC], ex_wc [MAXC], ex_sh [MAXC], ex_ev [MAXC];
    bit            ex_err[MAXC], ex_rv [MAXC], ex_addr[MAXC], ex_zero[MAXC];
    logic [4:0]    ex_row[MAXC], ex_col[MAXC];
    logic [DW-1:0] ex_data[MAXC], ex_rdata[MAXC];
    logic [DW-1:0] mc [DIM][DIM] = '{default: '0};
    logic [DW-1:0] model_racc = '0;
    int            cyc = 0;
    int            idle_from = 0;
    bit            last_acc, last_stall;
    int            n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_at(input int k);
        ex_wa[k] = 0; ex_wb[k] = 0; ex_wc[k] = 0; ex_sh[k] = 0; ex_ev[k] = 0;
        ex_err[k] = 0; ex_rv[k] = 0; ex_addr[k] = 0; ex_zero[k] = 0;
    endtask

    function automatic bit cmd_now();
        return ({start_i, write_enable_A_i, write_enable_B_i, write_enable_C_i, read_acc_i} != 5'd0)
               && !flush_i;
    endfunction

    task automatic check_outputs();
        if (ex_zero[cyc]) model_racc = '0;
        if (ex_rv[cyc])   model_racc = ex_rdata[cyc];
        chk("we_a",       arr_we_a_o,   ex_wa[cyc]);
        chk("we_b",       arr_we_b_o,   ex_wb[cyc]);
        chk("we_c",       arr_we_c_o,   ex_wc[cyc]);
        chk("shift",      arr_shift_o,  ex_sh[cyc]);
        chk("e_valid",    e_valid_o,    ex_ev[cyc]);
        chk("err",        err_o,        ex_err[cyc]);
        chk("racc_valid", racc_valid_o, ex_rv[cyc]);
        chk("racc_data",  racc_data_o,  model_racc);
        chk("stall",      stall_o,      cmd_now() && (cyc < idle_from));
        if (ex_wa[cyc] || ex_wb[cyc] || ex_wc[cyc] || ex_addr[cyc]) begin
            chk("row", arr_row_o, ex_row[cyc]);
            chk("col", arr_col_o, ex_col[cyc]);
        end
        if (ex_wa[cyc] || ex_wb[cyc] || ex_wc[cyc]) chk("data", arr_data_o, ex_data[cyc]);
    endtask

    task automatic model_step();
        logic [4:0] vec;
        bit         cmd, ill;
        vec = {start_i, write_enable_A_i, write_enable_B_i, write_enable_C_i, read_acc_i};
        cmd = cmd_now();
        last_acc   = 0;
        last_stall = cmd && (cyc < idle_from);
        if (rst_i) begin
            for (int k = cyc + 1; k < cyc + SEQ + 4; k++) clear_at(k);
            ex_zero[cyc + 1] = 1;
            idle_from = cyc + 1;
            return;
        end
        if (!cmd || cyc < idle_from) return;
        last_acc = 1;
        ill = ($countones(vec) > 1) ||
              (!start_i && (int'(row_i) >= DIM || int'(col_i) >= DIM));
        if (ill) begin
            ex_err[cyc + 1] = 1;
        end else if (start_i) begin
            for (int k = 1; k <= SEQ; k++) ex_sh[cyc + k] = 1;
            ex_ev[cyc + SEQ + 1] = 1;
            idle_from = cyc + SEQ + 2;
        end else begin
            ex_row[cyc + 1]  = row_i;
            ex_col[cyc + 1]  = col_i;
            ex_data[cyc + 1] = data_i;
            ex_wa[cyc + 1]   = write_enable_A_i;
            ex_wb[cyc + 1]   = write_enable_B_i;
            ex_wc[cyc + 1]   = write_enable_C_i;
            if (write_enable_C_i) mc[row_i[2:0]][col_i[2:0]] = data_i;
            if (read_acc_i) begin
                ex_addr[cyc + 1]  = 1;
                ex_rv[cyc + 2]    = 1;
                ex_rdata[cyc + 2] = mc[row_i[2:0]][col_i[2:0]];
            end
        end
    endtask

    // One clock cycle: inputs are already applied just after the rising edge.
    task automatic run_cycle();
        if (cyc + SEQ + 4 >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        #1;
        if (cyc >= 1) check_outputs();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_in(input bit st, input bit wa, input bit wb, input bit wc, input bit ra,
                          input int row, input int col, input logic [DW-1:0] d,
                          input bit fl, input bit rs);
        start_i = st; write_enable_A_i = wa; write_enable_B_i = wb;
        write_enable_C_i = wc; read_acc_i = ra;
        row_i = 5'(row); col_i = 5'(col); data_i = d;
        flush_i = fl; rst_i = rs;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
        repeat (n) run_cycle();
    endtask

    // Present a command and hold it until the model accepts it (bounded).
    task automatic issue(input bit st, input bit wa, input bit wb, input bit wc, input bit ra,
                         input int row, input int col, input logic [DW-1:0] d);
        set_in(st, wa, wb, wc, ra, row, col, d, 0, 0);
        for (int i = 0; i < 40; i++) begin
            run_cycle();
            if (last_acc) break;
        end
        chk("accept", last_acc, 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
    endtask

    // Every completed matmul must have been preceded by exactly 3*DIM-2 shift cycles.
    int shift_run = 0;
    always @(negedge clk) begin
        if (arr_shift_o === 1'b1) begin
            shift_run = shift_run + 1;
        end else begin
            if (e_valid_o === 1'b1) chk("shift_len", shift_run, SEQ);
            shift_run = 0;
        end
    end

    initial begin
        logic [4:0] vec;
        bit         holding;
        int         r, b1, b2;

        set_in(0, 0, 0, 0, 0, 0, 0, '0, 0, 1);
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        idle(3);

        issue(0, 1, 0, 0, 0, 2, 3, 32'hDEAD_BEEF);
        idle(2);

        issue(1, 0, 0, 0, 0, 0, 0, '0);
        issue(0, 0, 1, 0, 0, 4, 5, 32'h0000_1234);
        idle(3);

        issue(0, 0, 0, 1, 0, 1, 1, 32'h0000_0055);
        issue(0, 0, 0, 0, 1, 1, 1, '0);
        idle(4);

        issue(1, 1, 0, 0, 0, 0, 0, 32'h1);
        idle(2);
        issue(0, 1, 0, 0, 0, 8, 0, 32'h2);
        idle(2);
        set_in(1, 0, 0, 0, 0, 0, 0, '0, 1, 0);
        run_cycle();
        idle(3);

        issue(1, 0, 0, 0, 0, 0, 0, '0);
        idle(9);
        set_in(0, 0, 0, 0, 0, 0, 0, '0, 0, 1);
        run_cycle();
        idle(4);

        holding = 0;
        for (int i = 0; i < 1800; i++) begin
            if (!holding) begin
                r   = $urandom_range(0, 99);
                vec = 5'd0;
                if      (r < 30) vec = 5'd0;
                else if (r < 42) vec = 5'b01000;
                else if (r < 54) vec = 5'b00100;
                else if (r < 66) vec = 5'b00010;
                else if (r < 80) vec = 5'b00001;
                else if (r < 86) vec = 5'b10000;
                else begin
                    b1 = $urandom_range(0, 4);
                    b2 = (b1 + $urandom_range(1, 4)) % 5;
                    vec[b1] = 1'b1;
                    vec[b2] = 1'b1;
                end
                row_i  = 5'($urandom_range(0, DIM - 1));
                col_i  = 5'($urandom_range(0, DIM - 1));
                if ($urandom_range(0, 19) == 0) row_i = 5'($urandom_range(DIM, 31));
                if ($urandom_range(0, 19) == 0) col_i = 5'($urandom_range(DIM, 31));
                data_i  = $urandom();
                flush_i = ($urandom_range(0, 19) == 0);
                rst_i   = ($urandom_range(0, 199) == 0);
                if (rst_i) vec = 5'd0;
                {start_i, write_enable_A_i, write_enable_B_i, write_enable_C_i, read_acc_i} = vec;
            end else begin
                flush_i = 0;
                rst_i   = 0;
            end
            run_cycle();
            holding = last_stall;
        end
        idle(SEQ + 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
